led_display_frame_writer: RTL

// Upstream stage of the frame RAM. Accepts a raster-order RGB pixel stream (valid/ready, SOF-marked),

---
 rtl/led_display_frame_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/led_display_frame_writer.sv
// ---------------------------------------------------------------------------
// led_display_frame_writer
//
// Purpose:
//   Upstream stage of the LED panel frame RAM. Takes a raster-order 3-bit RGB
//   pixel stream (valid/ready handshake, first pixel marked by SOF). It packs
//   8 pixels per 32-bit word, one {0,B,G,R} nibble per pixel with column 0 in
//   the low nibble. Complete words are written into frame_ram port A.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous reset, active-high
//   pixel_in        {B,G,R} colour bits of the current pixel
//   pixel_sof_in    first pixel of a frame (row 0, col 0)
//   pixel_valid_in  pixel_in / pixel_sof_in valid
//   pixel_ready_out writer can accept a pixel this cycle (combinational)
//   ram_busy_in     frame_ram reset busy; stalls the writer
//   ram_wen_out     frame_ram byte enables (4'hF for one cycle per word)
//   ram_addr_out    frame_ram byte address
//   ram_wdata_out   frame_ram write data
//   frame_done_out  1-cycle pulse together with the last word of a frame
//   sof_error_out   1-cycle pulse when SOF arrives in the middle of a frame
// ---------------------------------------------------------------------------
module led_display_frame_writer #(
  parameter int unsigned NUM_ROW_PIXELS = 32,
  parameter int unsigned NUM_COL_PIXELS = 64,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [2:0]  pixel_in,
  input  logic        pixel_sof_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  input  logic        ram_busy_in,
  output logic [3:0]  ram_wen_out,
  output logic [31:0] ram_addr_out,
  output logic [31:0] ram_wdata_out,
  output logic        frame_done_out,
  output logic        sof_error_out
);

  localparam int unsigned COL_W         = $clog2(NUM_COL_PIXELS);
  localparam int unsigned ROW_W         = $clog2(NUM_ROW_PIXELS);
  localparam int unsigned WORDS_PER_ROW = NUM_COL_PIXELS / 8;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL_PIXELS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW_PIXELS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  // Only slots 0..6 need storage: slot 7 goes straight from pixel_in into
  // the outgoing word on the beat that completes it.
  logic [27:0]      word_reg, word_next;
  logic [3:0]       wen_reg, wen_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic             done_reg, done_next;
  logic             sof_err_reg, sof_err_next;

  logic             accept;
  logic [3:0]       nibble;
  logic [2:0]       slot;
  logic [31:0]      word_idx;

  assign pixel_ready_out = !rst_in && !ram_busy_in;
  assign accept          = pixel_valid_in && pixel_ready_out;
  assign nibble          = {1'b0, pixel_in};
  assign slot            = col_reg[2:0];
  assign word_idx        = 32'(row_reg) * 32'(WORDS_PER_ROW) + (32'(col_reg) >> 3);

  assign ram_wen_out     = wen_reg;
  assign ram_addr_out    = addr_reg;
  assign ram_wdata_out   = wdata_reg;
  assign frame_done_out  = done_reg;
  assign sof_error_out   = sof_err_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      word_reg    <= '0;
      wen_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      done_reg    <= 1'b0;
      sof_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      word_reg    <= word_next;
      wen_reg     <= wen_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      done_reg    <= done_next;
      sof_err_reg <= sof_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    word_next    = word_reg;
    wen_next     = 4'h0;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    done_next    = 1'b0;
    sof_err_next = 1'b0;

    if (accept) begin
      unique case (state_reg)
        IDLE: begin
          // Anything before the first SOF is dropped on the floor.
          if (pixel_sof_in) begin
            word_next  = {24'h0, nibble};
            col_next   = COL_W'(1);
            row_next   = '0;
            state_next = ACTIVE;
          end
        end

        ACTIVE: begin
          // A beat landing in slot 7 completes the word at the current
          // address, even if it also carries a restarting SOF.
          if (slot == 3'd7) begin
            wen_next   = 4'hF;
            addr_next  = BASE_ADDR + (word_idx << 2);
            wdata_next = {nibble, word_reg};
          end

          if (pixel_sof_in) begin
            // Restart: the partial word is abandoned and the SOF pixel
            // becomes column 0 of the new frame.
            sof_err_next = 1'b1;
            word_next    = {24'h0, nibble};
            col_next     = COL_W'(1);
            row_next     = '0;
          end else begin
            if (slot != 3'd7) begin
              word_next[{slot, 2'b00} +: 4] = nibble;
            end
            if (col_reg == LAST_COL) begin
              col_next = '0;
              if (row_reg == LAST_ROW) begin
                row_next   = '0;
                done_next  = 1'b1;
                state_next = IDLE;
              end else begin
                row_next = row_reg + ROW_W'(1);
              end
            end else begin
              col_next = col_reg + COL_W'(1);
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

endmodule
